// File: rtl/wallace_pkg.sv
// Shared constants and elaboration-time helpers for the Wallace-tree multiplier.
// Optional feature macro: WALLACE_SIGNED_EN (adds Baugh-Wooley signed mode).
package wallace_pkg;

  localparam int W_DEF        = 24;
  localparam int LOW_BITS_DEF = 8;
  localparam int TAG_W_DEF    = 4;

  // Height of the partial-product bit matrix after 'layers' rounds of 3:2 counters.
  function automatic int csa_height(input int h0, input int layers);
    int h;
    h = h0;
    for (int k = 0; k < layers; k++) h = 2 * (h / 3) + h % 3;
    return h;
  endfunction

  // Number of 3:2 layers needed to bring a matrix of height h0 down to two rows.
  function automatic int csa_layers(input int h0);
    int h;
    int n;
    h = h0;
    n = 0;
    while (h > 2) begin
      h = 2 * (h / 3) + h % 3;
      n++;
    end
    return n;
  endfunction

  // Baugh-Wooley constant: ones at columns w and 2w-1 of the 2w-bit product.
  function automatic logic [63:0] bw_correction(input int w);
    logic [63:0] c;
    c = '0;
    c[w]       = 1'b1;
    c[2*w - 1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/wallace_csa_tree.sv
// Combinational Wallace reduction: partial products -> carry-save high part plus
// resolved low product bits. Optional macro: WALLACE_SIGNED_EN (Baugh-Wooley terms).
module wallace_csa_tree
  import wallace_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int LOW_BITS = LOW_BITS_DEF
) (
  input  logic [W-1:0]            a,
  input  logic [W-1:0]            b,
`ifdef WALLACE_SIGNED_EN
  input  logic                    sgn,
`endif
  output logic [2*W-LOW_BITS-1:0] x,
  output logic [2*W-LOW_BITS-1:0] y,
  output logic [LOW_BITS-1:0]     z_low
);

  localparam int PW = 2 * W;
  localparam int HW = PW - LOW_BITS;
`ifdef WALLACE_SIGNED_EN
  localparam int H0 = W + 1;  // extra row carries the sign-correction constant
  localparam logic [63:0] BW_C = bw_correction(W);
`else
  localparam int H0 = W;
`endif
  localparam int NL = csa_layers(H0);

  // rows[level][row]: matrix rows entering each reduction layer
  logic [PW-1:0] rows [NL+1][H0];

  // Partial-product rows, each shifted into its column position
  for (genvar gi = 0; gi < W; gi++) begin : g_pp
    logic [W-1:0] pp;
`ifdef WALLACE_SIGNED_EN
    logic [W-1:0] flip;
    // Invert the terms where exactly one operand bit is a sign bit
    assign flip = (gi == W - 1) ? {1'b0, {(W-1){sgn}}} : {sgn, {(W-1){1'b0}}};
    assign pp   = (a & {W{b[gi]}}) ^ flip;
`else
    assign pp = a & {W{b[gi]}};
`endif
    assign rows[0][gi] = {{W{1'b0}}, pp} << gi;
  end
`ifdef WALLACE_SIGNED_EN
  assign rows[0][W] = sgn ? BW_C[PW-1:0] : '0;
`endif

  // 3:2 counter layers: every full group of three rows becomes a sum and a carry row
  for (genvar li = 0; li < NL; li++) begin : g_layer
    localparam int H = csa_height(H0, li);
    localparam int G = H / 3;
    localparam int R = H % 3;
    for (genvar gi = 0; gi < G; gi++) begin : g_csa
      logic [PW-1:0] r0, r1, r2;
      assign r0 = rows[li][3*gi];
      assign r1 = rows[li][3*gi+1];
      assign r2 = rows[li][3*gi+2];
      assign rows[li+1][2*gi]   = r0 ^ r1 ^ r2;
      assign rows[li+1][2*gi+1] = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
    end
    for (genvar gi = 0; gi < R; gi++) begin : g_pass
      assign rows[li+1][2*G+gi] = rows[li][3*G+gi];
    end
    for (genvar gi = 2*G+R; gi < H0; gi++) begin : g_empty
      assign rows[li+1][gi] = '0;
    end
  end

  logic [PW-1:0]     fin0, fin1;
  logic [LOW_BITS:0] low_sum;
  logic [HW-1:0]     hp, hq, hc;

  assign fin0 = rows[NL][0];
  assign fin1 = rows[NL][1];

  // Resolve the low columns here; their carry is folded into the high carry-save pair
  assign low_sum = {1'b0, fin0[LOW_BITS-1:0]} + {1'b0, fin1[LOW_BITS-1:0]};
  assign z_low   = low_sum[LOW_BITS-1:0];
  assign hp      = fin0[PW-1:LOW_BITS];
  assign hq      = fin1[PW-1:LOW_BITS];
  assign hc      = {{(HW-1){1'b0}}, low_sum[LOW_BITS]};
  assign x       = hp ^ hq ^ hc;
  assign y       = ((hp & hq) | (hp & hc) | (hq & hc)) << 1;

endmodule

// File: rtl/wallace_pipe_mul.sv
// Two-stage pipelined Wallace multiplier with valid/ready handshakes and a tag.
// Stage 1 registers the tree's carry-save output, stage 2 the final product.
// Optional macro: WALLACE_SIGNED_EN (adds the sgn port for two's-complement mode).
module wallace_pipe_mul
  import wallace_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int LOW_BITS = LOW_BITS_DEF,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
`ifdef WALLACE_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [TAG_W-1:0] tag_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2*W-1:0]   z,
  output logic [TAG_W-1:0] tag_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int HW = 2 * W - LOW_BITS;

  logic [HW-1:0]       tree_x, tree_y;
  logic [LOW_BITS-1:0] tree_z_low;

  wallace_csa_tree #(.W(W), .LOW_BITS(LOW_BITS)) u_tree (
    .a     (a),
    .b     (b),
`ifdef WALLACE_SIGNED_EN
    .sgn   (sgn),
`endif
    .x     (tree_x),
    .y     (tree_y),
    .z_low (tree_z_low)
  );

  logic                s1_valid_reg, s2_valid_reg;
  logic [HW-1:0]       s1_x_reg, s1_y_reg;
  logic [LOW_BITS-1:0] s1_z_low_reg;
  logic [TAG_W-1:0]    s1_tag_reg, tag_out_reg;
  logic [2*W-1:0]      z_reg;
  logic                s1_en, s2_en;
  logic [HW-1:0]       hi_sum;

  // A stage may load when it is empty or its contents move on this cycle
  assign s2_en    = !s2_valid_reg | out_ready;
  assign s1_en    = !s1_valid_reg | s2_en;
  assign in_ready = s1_en;

  // Final carry-propagate add on the high part; carry beyond 2W-1 is dropped
  assign hi_sum = s1_x_reg + s1_y_reg;

  // Stage 1: capture tree output and tag on accept, hold while stalled
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_valid_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_y_reg     <= '0;
      s1_z_low_reg <= '0;
      s1_tag_reg   <= '0;
    end else if (s1_en) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_x_reg     <= tree_x;
        s1_y_reg     <= tree_y;
        s1_z_low_reg <= tree_z_low;
        s1_tag_reg   <= tag_in;
      end
    end
  end

  // Stage 2: capture the resolved product when stage 1 advances, hold while stalled
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s2_valid_reg <= 1'b0;
      z_reg        <= '0;
      tag_out_reg  <= '0;
    end else if (s2_en) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        z_reg       <= {hi_sum, s1_z_low_reg};
        tag_out_reg <= s1_tag_reg;
      end
    end
  end

  assign z         = z_reg;
  assign tag_out   = tag_out_reg;
  assign out_valid = s2_valid_reg;

endmodule

// File: tb/tb_wallace_pipe_mul.sv
// Self-checking bench for wallace_pipe_mul: directed corner products, latency,
// back-to-back streaming, backpressure, mid-stream reset and a random stress run.
// Build with WALLACE_SIGNED_EN defined to also exercise signed mode.
module tb_wallace_pipe_mul;

  localparam int W = 24;
  localparam int L = 8;
  localparam int T = 4;

  typedef struct packed {
    logic [2*W-1:0] z;
    logic [T-1:0]   tag;
  } exp_t;

  logic           clk = 1'b0;
  logic           clrn = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           sgn = 1'b0;
  logic [T-1:0]   tag_in = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] z;
  logic [T-1:0]   tag_out;
  logic           out_valid;
  logic           out_ready;
  logic           ready_ctl = 1'b1;
  logic           rand_mode = 1'b0;
  logic           rnd_ready = 1'b1;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  logic           hold_pending = 1'b0;
  logic [2*W-1:0] hold_z = '0;
  logic [T-1:0]   hold_tag = '0;
  int             cur_run = 0;
  int             last_run = 0;

  assign out_ready = rand_mode ? rnd_ready : ready_ctl;

  always #5 clk = ~clk;

  wallace_pipe_mul #(.W(W), .LOW_BITS(L), .TAG_W(T)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .a         (a),
    .b         (b),
`ifdef WALLACE_SIGNED_EN
    .sgn       (sgn),
`endif
    .tag_in    (tag_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .tag_out   (tag_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Reference product: extend both operands to 2W bits and multiply
  function automatic logic [2*W-1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                           input logic s);
    logic [2*W-1:0] xe, ye;
    xe = s ? {{W{xa[W-1]}}, xa} : {{W{1'b0}}, xa};
    ye = s ? {{W{xb[W-1]}}, xb} : {{W{1'b0}}, xb};
    return xe * ye;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  // Random consumer readiness for the stress phase
  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: scoreboard every output handshake, check stall stability, log accepts
  always @(negedge clk) begin
    exp_t e;
    if (!clrn) begin
      exp_q.delete();
      hold_pending = 1'b0;
      cur_run      = 0;
    end else begin
      if (hold_pending) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_z", 64'(z), 64'(hold_z));
        check("stall_tag", 64'(tag_out), 64'(hold_tag));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got z=%h tag=%0d expected no output", z, tag_out);
        end else begin
          e = exp_q.pop_front();
          $display("txn out z=%h tag=%0d exp_z=%h exp_tag=%0d", z, tag_out, e.z, e.tag);
          check("out_z", 64'(z), 64'(e.z));
          check("out_tag", 64'(tag_out), 64'(e.tag));
        end
      end
      if (out_valid) cur_run++;
      else begin
        if (cur_run != 0) last_run = cur_run;
        cur_run = 0;
      end
      hold_pending = out_valid && !out_ready;
      hold_z       = z;
      hold_tag     = tag_out;
      if (in_valid && in_ready) exp_q.push_back('{model(a, b, sgn), tag_in});
    end
  end

  // Present one request and hold it until the handshake edge has passed
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                      input logic [T-1:0] tv);
    logic acc;
    a        = av;
    b        = bv;
`ifdef WALLACE_SIGNED_EN
    sgn      = sv;
`else
    sgn      = 1'b0 & sv;
`endif
    tag_in   = tv;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected accept");
    end
    in_valid = 1'b0;
  endtask

  // Single request on an idle pipeline: checks latency and a literal product
  task automatic directed(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic sv, input logic [T-1:0] tv, input logic [2*W-1:0] exp_z);
    send(av, bv, sv, tv);
    check({name, "_lat_early"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check({name, "_lat_valid"}, 64'(out_valid), 64'd1);
    check({name, "_z"}, 64'(z), 64'(exp_z));
    check({name, "_tag"}, 64'(tag_out), 64'(tv));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  acc_cnt;
    logic r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_z", 64'(z), 64'd0);
    check("rst_tag", 64'(tag_out), 64'd0);
    clrn = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed corner products
    directed("max_sq", 24'hFFFFFF, 24'hFFFFFF, 1'b0, 4'd3, 48'hFFFFFE000001);
    directed("zero", 24'h000000, 24'hABCDEF, 1'b0, 4'd5, 48'h0);
    directed("one_msb", 24'h000001, 24'h800000, 1'b0, 4'd9, 48'h000000800000);
`ifdef WALLACE_SIGNED_EN
    directed("s_m1x2", 24'hFFFFFF, 24'h000002, 1'b1, 4'd1, 48'hFFFFFFFFFFFE);
    directed("s_minsq", 24'h800000, 24'h800000, 1'b1, 4'd2, 48'h400000000000);
`endif

    // Back-to-back stream of 16 with the consumer always ready
    for (int i = 0; i < 16; i++) send(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), T'(i));
    drain("stream");
    check("stream_run", 64'(last_run), 64'd16);

    // Backpressure: exactly two requests are absorbed, then in_ready drops
    ready_ctl = 1'b0;
    acc_cnt   = 0;
    a = rnd_operand(); b = rnd_operand(); tag_in = T'(acc_cnt);
    in_valid  = 1'b1;
    repeat (8) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc_cnt++;
        a = rnd_operand(); b = rnd_operand(); tag_in = T'(acc_cnt);
      end
    end
    check("bp_accepts", 64'(acc_cnt), 64'd2);
    @(negedge clk);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    ready_ctl = 1'b1;
    drain("bp");

    // Reset with both stages full
    ready_ctl = 1'b0;
    send(24'h123456, 24'h654321, 1'b0, 4'd7);
    send(24'h00FFFF, 24'h000F0F, 1'b0, 4'd8);
    check("rst_pre_full", 64'(out_valid), 64'd1);
    clrn = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_z", 64'(z), 64'd0);
    check("midrst_tag", 64'(tag_out), 64'd0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    ready_ctl = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("midrst_empty", 64'(out_valid), 64'd0);
    directed("post_rst", 24'h000101, 24'h000303, 1'b0, 4'd4, 48'h00000003 * 48'h0 + 48'h30603);

    // Random stress with input gaps and random consumer stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)), T'($urandom));
    end
    rand_mode = 1'b0;
    drain("stress");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
